// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch, wait-on-imem, redirects
// (branch/jalr/trap) and misaligned-target trapping.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch issued
// RUN   | fetching at PC, advances when imem accepts
// WAIT  | fetch at PC not yet accepted by imem
// FAULT | misaligned redirect trapped, fetch suppressed one cycle
module pc_gen #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              ALIGN        = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] pc_ex,
  input  logic [WIDTH-1:0] immop,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             misalign
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT, FAULT} state_e;

  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN) - WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misalign_q, misalign_d;

  logic [WIDTH-1:0] sum_jalr;
  logic [WIDTH-1:0] trap_tgt;
  logic [WIDTH-1:0] target;
  logic             redirect;
  logic             tgt_misaligned;

  assign sum_jalr = rs1 + immop;
  assign trap_tgt = trap_vec & ~ALIGN_MASK;
  assign redirect = (pc_src != 2'b00);

  always_comb begin
    target = trap_tgt;
    case (pc_src)
      2'b01:   target = pc_ex + immop;
      2'b10:   target = sum_jalr & ~WIDTH'(1);
      default: target = trap_tgt;
    endcase
  end

  // Trap redirects are force-aligned, so only branch/jalr can fault.
  assign tgt_misaligned = (pc_src != 2'b11) && ((target & ALIGN_MASK) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (redirect) begin
      if (tgt_misaligned) begin
        pc_d       = trap_tgt;
        misalign_d = 1'b1;
        state_d    = FAULT;
      end else begin
        pc_d    = target;
        state_d = RUN;
      end
    end else begin
      case (state_q)
        BOOT:  state_d = RUN;
        RUN: begin
          if (!stall) begin
            if (imem_ready) pc_d = pc_q + WIDTH'(4);
            else            state_d = WAIT;
          end
        end
        WAIT:  if (imem_ready) state_d = RUN;
        FAULT: state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_comb begin
    fetch_valid = 1'b0;
    case (state_q)
      RUN, WAIT: fetch_valid = 1'b1;
      default:   fetch_valid = 1'b0;
    endcase
  end

  assign PC       = pc_q;
  assign pc_plus4 = pc_q + WIDTH'(4);
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand-written reset
// sequences, and randomized traffic against a behavioural model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  pc_src;
  logic [31:0] pc_ex, immop, rs1, trap_vec;
  logic        imem_ready;
  logic [31:0] PC, pc_plus4;
  logic        fetch_valid, misalign;

  int total = 0;
  int bad   = 0;

  pc_gen #(.WIDTH(32), .RESET_VECTOR(32'h0), .ALIGN(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src), .pc_ex(pc_ex),
    .immop(immop), .rs1(rs1), .trap_vec(trap_vec), .imem_ready(imem_ready),
    .PC(PC), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  src;
    logic [31:0] ex, imm, r1, tv;
    logic        rdy;
    logic [31:0] epc;
    logic        efv, emis;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: phase flags rather than an encoded state.
  logic [31:0] m_pc;
  logic        m_boot, m_wait, m_fault, m_mis;

  task automatic add(input logic st, input logic [1:0] src, input logic [31:0] ex,
                     input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] tv,
                     input logic rdy, input logic [31:0] epc, input logic efv,
                     input logic emis);
    vec_t v;
    v.stall = st; v.src = src; v.ex = ex; v.imm = imm; v.r1 = r1; v.tv = tv;
    v.rdy = rdy; v.epc = epc; v.efv = efv; v.emis = emis;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [1:0] src, input logic [31:0] ex,
                       input logic [31:0] imm, input logic [31:0] r1,
                       input logic [31:0] tv, input logic rdy);
    stall = st; pc_src = src; pc_ex = ex; immop = imm; rs1 = r1; trap_vec = tv;
    imem_ready = rdy;
  endtask

  task automatic check(input string nm, input logic [31:0] epc, input logic efv,
                       input logic emis);
    total++;
    if (PC !== epc) begin
      bad++; $display("FAIL %s PC got=%h exp=%h", nm, PC, epc);
    end
    total++;
    if (pc_plus4 !== epc + 32'd4) begin
      bad++; $display("FAIL %s pc_plus4 got=%h exp=%h", nm, pc_plus4, epc + 32'd4);
    end
    total++;
    if (fetch_valid !== efv) begin
      bad++; $display("FAIL %s fetch_valid got=%b exp=%b", nm, fetch_valid, efv);
    end
    total++;
    if (misalign !== emis) begin
      bad++; $display("FAIL %s misalign got=%b exp=%b", nm, misalign, emis);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset;
    m_pc = 32'h0; m_boot = 1'b1; m_wait = 1'b0; m_fault = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic [1:0] src, input logic [31:0] ex,
                            input logic [31:0] imm, input logic [31:0] r1,
                            input logic [31:0] tv, input logic rdy);
    logic [31:0] t, s, trap_t;
    trap_t = tv - (tv % 32'd4);
    m_mis  = 1'b0;
    if (src != 2'd0) begin
      if (src == 2'd1) t = ex + imm;
      else if (src == 2'd2) begin s = r1 + imm; t = s - (s % 32'd2); end
      else t = trap_t;
      m_boot = 1'b0; m_wait = 1'b0;
      if (src != 2'd3 && (t % 32'd4) != 32'd0) begin
        m_pc = trap_t; m_mis = 1'b1; m_fault = 1'b1;
      end else begin
        m_pc = t; m_fault = 1'b0;
      end
    end else if (m_boot)  m_boot = 1'b0;
    else if (m_fault)     m_fault = 1'b0;
    else if (m_wait)      begin if (rdy) m_wait = 1'b0; end
    else if (!st) begin
      if (rdy) m_pc = m_pc + 32'd4;
      else     m_wait = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);

    add(0, 2'd0, 0, 0, 0, 0, 1, 32'h0, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 1, 32'h4, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 1, 32'h8, 1, 0);
    add(0, 2'd1, 32'hF0, 32'h10, 0, 0, 1, 32'h100, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 0, 32'h100, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 0, 32'h100, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 1, 32'h100, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 1, 32'h104, 1, 0);
    add(0, 2'd1, 32'h100, 32'h100, 0, 0, 1, 32'h200, 1, 0);
    add(1, 2'd1, 32'h1F8, 32'h10, 0, 0, 0, 32'h208, 1, 0);
    add(1, 2'd0, 0, 0, 0, 0, 1, 32'h208, 1, 0);
    add(0, 2'd2, 0, 32'h2, 32'h301, 32'h80, 1, 32'h80, 0, 1);
    add(0, 2'd0, 0, 0, 0, 32'h80, 1, 32'h80, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 1, 32'h84, 1, 0);
    add(0, 2'd2, 0, 32'h3, 32'h401, 0, 1, 32'h404, 1, 0);
    add(0, 2'd1, 32'hFFFF_FFF0, 32'hC, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 1, 32'h0, 1, 0);
    add(0, 2'd3, 0, 0, 0, 32'h83, 1, 32'h80, 1, 0);
    add(0, 2'd1, 32'h100, 32'h2, 0, 32'h40, 1, 32'h40, 0, 1);
    add(0, 2'd1, 32'h100, 32'h0, 0, 0, 1, 32'h100, 1, 0);
    add(0, 2'd2, 0, 32'hFFFF_FFFF, 32'h10, 32'h123, 1, 32'h120, 0, 1);
    add(0, 2'd0, 0, 0, 0, 0, 0, 32'h120, 1, 0);
    add(0, 2'd0, 0, 0, 0, 0, 0, 32'h120, 1, 0);
    add(0, 2'd3, 0, 0, 0, 32'h200, 0, 32'h200, 1, 0);
    add(0, 2'd2, 0, 32'h0, 32'h101, 0, 1, 32'h100, 1, 0);

    @(negedge clk);
    check("reset", 32'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].src, vecs[i].ex, vecs[i].imm, vecs[i].r1,
            vecs[i].tv, vecs[i].rdy);
      step();
      check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].efv, vecs[i].emis);
    end

    // Reset pulsed between edges while in WAIT, then redirect out of BOOT.
    drive(0, 2'd1, 32'h300, 32'h0, 0, 0, 1); step();
    check("pre_wait", 32'h300, 1, 0);
    drive(0, 2'd0, 0, 0, 0, 0, 0); step();
    check("in_wait", 32'h300, 1, 0);
    #1 rst = 1'b0;
    #1 check("async_rst", 32'h0, 0, 0);
    #1 rst = 1'b1;
    drive(0, 2'd0, 0, 0, 0, 0, 1); step();
    check("post_rst_run", 32'h0, 1, 0);
    step();
    check("post_rst_adv", 32'h4, 1, 0);
    rst = 1'b0; #1 rst = 1'b1;
    drive(0, 2'd1, 32'h40, 32'h4, 0, 0, 0); step();
    check("boot_redirect", 32'h44, 1, 0);

    // Randomized traffic against the model.
    rst = 1'b0; #1 rst = 1'b1;
    model_reset();
    for (int n = 0; n < 500; n++) begin
      logic        st, rdy;
      logic [1:0]  src;
      logic [31:0] ex, imm, r1, tv;
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      src = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      ex  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      r1  = $urandom;
      tv  = $urandom;
      drive(st, src, ex, imm, r1, tv, rdy);
      model_step(st, src, ex, imm, r1, tv, rdy);
      step();
      check($sformatf("rnd%0d", n), m_pc, !m_boot && !m_fault, m_mis);
      if ($urandom_range(0, 49) == 0) begin
        #1 rst = 1'b0;
        model_reset();
        #1 check($sformatf("rnd_rst%0d", n), m_pc, 1'b0, 1'b0);
        #1 rst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
